// File: rtl/aha_sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aha_sram_arb_pkg
// Description : Shared types for the two-port SRAM arbiter: FSM states,
//               port indices and the response pipeline record.
// Revision    : 1.0 - initial release
// ============================================================================
package aha_sram_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Travels alongside each SRAM access so the completion lands on the owner.
    typedef struct packed {
        logic valid;
        logic owner;
        logic is_write;
    } rsp_pipe_t;

endpackage
`default_nettype wire

// File: rtl/aha_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : aha_rr_arb2
// Description : Combinational two-request round-robin pick with request mask
//               and one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module aha_rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] w_req;

    assign w_req = req & mask;

    always_comb begin
        gnt = 2'b00;
        case (w_req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/aha_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aha_sram_port_arbiter
// Description : Shares one single-port SRAM macro between two requesters with
//               round-robin arbitration and a bounded grant lock.
// Revision    : 1.0 - initial release
// ============================================================================
module aha_sram_port_arbiter
    import aha_sram_arb_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 64,
    parameter int MAX_LOCK = 16,
    parameter int BE_W     = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARESETn,

    input  logic              p0_REQ_VALID,
    output logic              p0_REQ_READY,
    input  logic              p0_REQ_WE,
    input  logic [ADDR_W-1:0] p0_REQ_ADDR,
    input  logic [DATA_W-1:0] p0_REQ_WDATA,
    input  logic [BE_W-1:0]   p0_REQ_WBE,
    input  logic              p0_REQ_LOCK,
    output logic              p0_RSP_VALID,
    output logic [DATA_W-1:0] p0_RSP_RDATA,

    input  logic              p1_REQ_VALID,
    output logic              p1_REQ_READY,
    input  logic              p1_REQ_WE,
    input  logic [ADDR_W-1:0] p1_REQ_ADDR,
    input  logic [DATA_W-1:0] p1_REQ_WDATA,
    input  logic [BE_W-1:0]   p1_REQ_WBE,
    input  logic              p1_REQ_LOCK,
    output logic              p1_RSP_VALID,
    output logic [DATA_W-1:0] p1_RSP_RDATA,

    output logic              SRAM_CEn,
    output logic [BE_W-1:0]   SRAM_WEn,
    output logic [ADDR_W-1:0] SRAM_A,
    output logic [DATA_W-1:0] SRAM_D,
    input  logic [DATA_W-1:0] SRAM_Q
);

    localparam int                 c_cnt_w    = $clog2(MAX_LOCK + 1);
    localparam logic [c_cnt_w-1:0] c_max_lock = c_cnt_w'(MAX_LOCK);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic                r_rr_ptr;
    logic                w_rr_nxt;
    logic [c_cnt_w-1:0]  r_lock_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [c_cnt_w-1:0]  w_cnt_sat;

    logic [1:0]          w_req;
    logic [1:0]          w_mask;
    logic [1:0]          w_gnt_raw;
    logic [1:0]          w_gnt;
    logic                w_accept;
    logic                w_sel;
    logic                w_owner;
    logic                w_cur;
    logic                w_peer_valid;

    logic                w_beat_we;
    logic                w_beat_lock;
    logic [ADDR_W-1:0]   w_beat_addr;
    logic [DATA_W-1:0]   w_beat_wdata;
    logic [BE_W-1:0]     w_beat_wbe;

    logic                r_cen;
    logic [BE_W-1:0]     r_wen;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    rsp_pipe_t           w_pipe_in;
    rsp_pipe_t           r_pipe1;
    rsp_pipe_t           r_pipe2;

    logic [1:0]          w_rsp_valid;
    logic [DATA_W-1:0]   w_rsp_rdata [2];

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    assign w_req = {p1_REQ_VALID, p0_REQ_VALID};

    always_comb begin
        w_mask = 2'b11;
        case (r_state)
            LOCK0:   w_mask = 2'b01;
            LOCK1:   w_mask = 2'b10;
            default: w_mask = 2'b11;
        endcase
    end

    aha_rr_arb2 u_rr_arb2 (
        .req  (w_req),
        .ptr  (r_rr_ptr),
        .mask (w_mask),
        .gnt  (w_gnt_raw)
    );

    // Nothing is accepted while reset is asserted.
    assign w_gnt        = w_gnt_raw & {2{ARESETn}};
    assign w_accept     = |w_gnt;
    assign w_sel        = w_gnt[1] ? PORT1 : PORT0;
    assign p0_REQ_READY = w_gnt[0];
    assign p1_REQ_READY = w_gnt[1];

    assign w_owner      = (r_state == LOCK1) ? PORT1 : PORT0;
    assign w_cur        = (r_state == ARB) ? w_sel : w_owner;
    assign w_peer_valid = (w_cur == PORT1) ? p0_REQ_VALID : p1_REQ_VALID;

    always_comb begin
        w_beat_we    = p0_REQ_WE;
        w_beat_lock  = p0_REQ_LOCK;
        w_beat_addr  = p0_REQ_ADDR;
        w_beat_wdata = p0_REQ_WDATA;
        w_beat_wbe   = p0_REQ_WBE;
        if (w_sel == PORT1) begin
            w_beat_we    = p1_REQ_WE;
            w_beat_lock  = p1_REQ_LOCK;
            w_beat_addr  = p1_REQ_ADDR;
            w_beat_wdata = p1_REQ_WDATA;
            w_beat_wbe   = p1_REQ_WBE;
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM, round-robin pointer and lock counter
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_sat = r_lock_cnt;
        if (w_accept && (r_lock_cnt != c_max_lock)) begin
            w_cnt_sat = r_lock_cnt + c_cnt_one;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_lock_cnt;
        case (r_state)
            ARB: begin
                w_cnt_nxt = '0;
                if (w_accept) begin
                    w_rr_nxt = ~w_sel;
                    // With a lock limit of one the entering beat already
                    // exhausts the lock, so a waiting peer keeps us in ARB.
                    if (w_beat_lock && !((c_max_lock == c_cnt_one) && w_peer_valid)) begin
                        w_state_nxt = (w_sel == PORT1) ? LOCK1 : LOCK0;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
            end
            LOCK0, LOCK1: begin
                w_cnt_nxt = w_cnt_sat;
                if (w_accept && !w_beat_lock) begin
                    w_state_nxt = ARB;
                    w_cnt_nxt   = '0;
                end else if ((w_cnt_sat == c_max_lock) && w_peer_valid) begin
                    w_state_nxt = ARB;
                    w_cnt_nxt   = '0;
                    w_rr_nxt    = ~w_owner;
                end
            end
            default: begin
                w_state_nxt = ARB;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers: control, SRAM outputs, response pipeline
    // ------------------------------------------------------------------
    always_comb begin
        w_pipe_in          = '0;
        w_pipe_in.valid    = w_accept;
        w_pipe_in.owner    = w_sel;
        w_pipe_in.is_write = w_accept & w_beat_we;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state    <= ARB;
            r_rr_ptr   <= PORT0;
            r_lock_cnt <= '0;
            r_cen      <= 1'b1;
            r_wen      <= '1;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_pipe1    <= '0;
            r_pipe2    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_lock_cnt <= w_cnt_nxt;
            r_pipe1    <= w_pipe_in;
            r_pipe2    <= r_pipe1;
            if (w_accept) begin
                r_cen   <= 1'b0;
                r_addr  <= w_beat_addr;
                r_wdata <= w_beat_wdata;
                r_wen   <= w_beat_we ? ~w_beat_wbe : '1;
            end else begin
                r_cen   <= 1'b1;
                r_wen   <= '1;
            end
        end
    end

    assign SRAM_CEn = r_cen;
    assign SRAM_WEn = r_wen;
    assign SRAM_A   = r_addr;
    assign SRAM_D   = r_wdata;

    // Read data is a pass-through of the macro output in the completion cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        localparam logic c_port = (gi == 0) ? PORT0 : PORT1;
        assign w_rsp_valid[gi] = r_pipe2.valid && (r_pipe2.owner == c_port);
        assign w_rsp_rdata[gi] = (w_rsp_valid[gi] && !r_pipe2.is_write) ? SRAM_Q : '0;
    end

    assign p0_RSP_VALID = w_rsp_valid[0];
    assign p0_RSP_RDATA = w_rsp_rdata[0];
    assign p1_RSP_VALID = w_rsp_valid[1];
    assign p1_RSP_RDATA = w_rsp_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_aha_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aha_sram_port_arbiter
// Description : Directed self-checking bench for aha_sram_port_arbiter with a
//               behavioural 4Kx64 SRAM macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aha_sram_port_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 64;
    localparam int BE_W     = 8;
    localparam int MAX_LOCK = 4;

    logic              ACLK;
    logic              ARESETn;
    logic              p0_REQ_VALID, p0_REQ_READY, p0_REQ_WE, p0_REQ_LOCK, p0_RSP_VALID;
    logic [ADDR_W-1:0] p0_REQ_ADDR;
    logic [DATA_W-1:0] p0_REQ_WDATA, p0_RSP_RDATA;
    logic [BE_W-1:0]   p0_REQ_WBE;
    logic              p1_REQ_VALID, p1_REQ_READY, p1_REQ_WE, p1_REQ_LOCK, p1_RSP_VALID;
    logic [ADDR_W-1:0] p1_REQ_ADDR;
    logic [DATA_W-1:0] p1_REQ_WDATA, p1_RSP_RDATA;
    logic [BE_W-1:0]   p1_REQ_WBE;
    logic              SRAM_CEn;
    logic [BE_W-1:0]   SRAM_WEn;
    logic [ADDR_W-1:0] SRAM_A;
    logic [DATA_W-1:0] SRAM_D;
    logic [DATA_W-1:0] SRAM_Q;

    logic [DATA_W-1:0] mem [0:4095];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;

    int n_checks = 0;
    int n_errors = 0;

    int exp_lk_gnt [6] = '{0, 0, 0, 0, 1, 0};
    int exp_lk_cnt [6] = '{0, 1, 2, 3, 0, 0};

    aha_sram_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .p0_REQ_VALID (p0_REQ_VALID),
        .p0_REQ_READY (p0_REQ_READY),
        .p0_REQ_WE    (p0_REQ_WE),
        .p0_REQ_ADDR  (p0_REQ_ADDR),
        .p0_REQ_WDATA (p0_REQ_WDATA),
        .p0_REQ_WBE   (p0_REQ_WBE),
        .p0_REQ_LOCK  (p0_REQ_LOCK),
        .p0_RSP_VALID (p0_RSP_VALID),
        .p0_RSP_RDATA (p0_RSP_RDATA),
        .p1_REQ_VALID (p1_REQ_VALID),
        .p1_REQ_READY (p1_REQ_READY),
        .p1_REQ_WE    (p1_REQ_WE),
        .p1_REQ_ADDR  (p1_REQ_ADDR),
        .p1_REQ_WDATA (p1_REQ_WDATA),
        .p1_REQ_WBE   (p1_REQ_WBE),
        .p1_REQ_LOCK  (p1_REQ_LOCK),
        .p1_RSP_VALID (p1_RSP_VALID),
        .p1_RSP_RDATA (p1_RSP_RDATA),
        .SRAM_CEn     (SRAM_CEn),
        .SRAM_WEn     (SRAM_WEn),
        .SRAM_A       (SRAM_A),
        .SRAM_D       (SRAM_D),
        .SRAM_Q       (SRAM_Q)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Macro model: 1-cycle read latency, active-low byte write enables.
    always @(posedge ACLK) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (!SRAM_CEn) begin
            if (&SRAM_WEn) begin
                SRAM_Q <= mem[SRAM_A];
            end else begin
                for (int b = 0; b < BE_W; b++) begin
                    if (!SRAM_WEn[b]) mem[SRAM_A][b*8 +: 8] <= SRAM_D[b*8 +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_all();
        p0_REQ_VALID = 1'b0; p0_REQ_WE = 1'b0; p0_REQ_ADDR = '0;
        p0_REQ_WDATA = '0;   p0_REQ_WBE = '0;  p0_REQ_LOCK = 1'b0;
        p1_REQ_VALID = 1'b0; p1_REQ_WE = 1'b0; p1_REQ_ADDR = '0;
        p1_REQ_WDATA = '0;   p1_REQ_WBE = '0;  p1_REQ_LOCK = 1'b0;
    endtask

    task automatic drive(input int port, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] wbe, input logic lk);
        if (port == 0) begin
            p0_REQ_VALID = 1'b1; p0_REQ_WE = we; p0_REQ_ADDR = addr;
            p0_REQ_WDATA = wd;   p0_REQ_WBE = wbe; p0_REQ_LOCK = lk;
        end else begin
            p1_REQ_VALID = 1'b1; p1_REQ_WE = we; p1_REQ_ADDR = addr;
            p1_REQ_WDATA = wd;   p1_REQ_WBE = wbe; p1_REQ_LOCK = lk;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        logic [ADDR_W-1:0] prev_a;

        // Reset with preload; a valid request must not be accepted meanwhile.
        ARESETn = 1'b0;
        idle_all();
        pl_en   = 1'b1;
        pl_addr = 12'h010;
        pl_data = 64'hDEADBEEF_CAFEF00D;
        p0_REQ_VALID = 1'b1;
        cyc();
        pl_addr = 12'h020;
        pl_data = 64'hAAAAAAAA_AAAAAAAA;
        cyc();
        pl_en = 1'b0;
        cyc();
        settle();
        check("rst_p0_ready", p0_REQ_READY, 1'b0);
        check("rst_cen",      SRAM_CEn,     1'b1);
        check("rst_wen",      SRAM_WEn,     8'hFF);
        check("rst_a",        SRAM_A,       12'h000);
        check("rst_d",        SRAM_D,       64'h0);
        check("rst_rsp0",     p0_RSP_VALID, 1'b0);
        check("rst_rsp1",     p1_RSP_VALID, 1'b0);

        // Single read, accepted in the first cycle after release.
        cyc();
        ARESETn = 1'b1;
        idle_all();
        drive(0, 1'b0, 12'h010, 64'h0, 8'h00, 1'b0);
        settle();
        check("rd_p0_ready", p0_REQ_READY, 1'b1);
        cyc();
        idle_all();
        settle();
        check("rd_cen",  SRAM_CEn,     1'b0);
        check("rd_wen",  SRAM_WEn,     8'hFF);
        check("rd_a",    SRAM_A,       12'h010);
        check("rd_rsp_early", p0_RSP_VALID, 1'b0);
        cyc();
        settle();
        check("rd_rsp0",   p0_RSP_VALID, 1'b1);
        check("rd_rdata0", p0_RSP_RDATA, 64'hDEADBEEF_CAFEF00D);
        check("rd_rsp1",   p1_RSP_VALID, 1'b0);

        // Partial write from p1, then read back.
        cyc();
        drive(1, 1'b1, 12'h020, 64'h11223344_55667788, 8'h0F, 1'b0);
        settle();
        check("wr_p1_ready", p1_REQ_READY, 1'b1);
        cyc();
        idle_all();
        settle();
        check("wr_cen", SRAM_CEn, 1'b0);
        check("wr_wen", SRAM_WEn, 8'hF0);
        check("wr_a",   SRAM_A,   12'h020);
        check("wr_d",   SRAM_D,   64'h11223344_55667788);
        cyc();
        settle();
        check("wr_rsp1",   p1_RSP_VALID, 1'b1);
        check("wr_rdata1", p1_RSP_RDATA, 64'h0);
        check("wr_rsp0",   p0_RSP_VALID, 1'b0);
        cyc();
        drive(0, 1'b0, 12'h020, 64'h0, 8'h00, 1'b0);
        cyc();
        idle_all();
        cyc();
        settle();
        check("rb_rsp0",   p0_RSP_VALID, 1'b1);
        check("rb_rdata0", p0_RSP_RDATA, 64'hAAAAAAAA_55667788);

        // Write with no byte enables still accesses and completes.
        cyc();
        drive(1, 1'b1, 12'h010, 64'h0, 8'h00, 1'b0);
        cyc();
        idle_all();
        settle();
        check("wbe0_cen", SRAM_CEn, 1'b0);
        check("wbe0_wen", SRAM_WEn, 8'hFF);
        cyc();
        settle();
        check("wbe0_rsp1",   p1_RSP_VALID, 1'b1);
        check("wbe0_rdata1", p1_RSP_RDATA, 64'h0);

        // Reset in the cycle after a read is accepted: the read is dropped.
        cyc();
        drive(0, 1'b0, 12'h010, 64'h0, 8'h00, 1'b0);
        settle();
        check("mrst_p0_ready", p0_REQ_READY, 1'b1);
        cyc();
        idle_all();
        ARESETn = 1'b0;
        settle();
        check("mrst_ready_low", p0_REQ_READY | p1_REQ_READY, 1'b0);

        // Contention straight after release: strict alternation from port 0.
        for (int k = 0; k < 6; k++) begin
            cyc();
            ARESETn = 1'b1;
            drive(0, 1'b0, 12'(12'h100 + k), 64'h0, 8'h00, 1'b0);
            drive(1, 1'b0, 12'(12'h200 + k), 64'h0, 8'h00, 1'b0);
            settle();
            if (k == 0) begin
                check("mrst_cen", SRAM_CEn, 1'b1);
                check("mrst_wen", SRAM_WEn, 8'hFF);
                check("mrst_a",   SRAM_A,   12'h000);
                check("mrst_d",   SRAM_D,   64'h0);
            end
            check("cont_p0_ready", p0_REQ_READY, (k % 2) == 0);
            check("cont_p1_ready", p1_REQ_READY, (k % 2) == 1);
            check("cont_rsp0", p0_RSP_VALID, (k >= 2) && ((k % 2) == 0));
            check("cont_rsp1", p1_RSP_VALID, (k >= 2) && ((k % 2) == 1));
            if (k >= 1) begin
                prev_a = ((k - 1) % 2 == 0) ? 12'(12'h100 + k - 1) : 12'(12'h200 + k - 1);
                check("cont_cen", SRAM_CEn, 1'b0);
                check("cont_a",   SRAM_A,   prev_a);
            end
        end
        cyc();
        idle_all();
        settle();
        check("cont_last_cen", SRAM_CEn, 1'b0);
        check("cont_last_a",   SRAM_A,   12'h205);
        cyc();
        settle();
        check("cont_idle_cen", SRAM_CEn, 1'b1);

        // Lock: p0 holds LOCK with p1 waiting; broken after MAX_LOCK beats.
        for (int k = 0; k < 6; k++) begin
            cyc();
            idle_all();
            drive(0, 1'b0, 12'(12'h300 + k), 64'h0, 8'h00, 1'b1);
            drive(1, 1'b0, 12'h3F0, 64'h0, 8'h00, 1'b0);
            settle();
            check("lk_p0_ready", p0_REQ_READY, exp_lk_gnt[k] == 0);
            check("lk_p1_ready", p1_REQ_READY, exp_lk_gnt[k] == 1);
            check("lk_cnt", dut.r_lock_cnt, 64'(exp_lk_cnt[k]));
        end

        // Lock held while the owner goes idle: peer stays blocked, SRAM idle.
        for (int j = 0; j < 3; j++) begin
            cyc();
            idle_all();
            drive(1, 1'b0, 12'h3F0, 64'h0, 8'h00, 1'b0);
            settle();
            check("lkidle_p1_ready", p1_REQ_READY, 1'b0);
            if (j > 0) check("lkidle_cen", SRAM_CEn, 1'b1);
            if (j == 2) check("lkidle_cnt", dut.r_lock_cnt, 64'd1);
        end
        cyc();
        drive(0, 1'b0, 12'h3A0, 64'h0, 8'h00, 1'b0);
        settle();
        check("lkrel_cen",      SRAM_CEn,     1'b1);
        check("lkrel_p0_ready", p0_REQ_READY, 1'b1);
        check("lkrel_p1_ready", p1_REQ_READY, 1'b0);
        cyc();
        idle_all();
        drive(1, 1'b0, 12'h3F0, 64'h0, 8'h00, 1'b0);
        settle();
        check("lkrel_p1_next", p1_REQ_READY, 1'b1);
        check("lkrel_cnt",     dut.r_lock_cnt, 64'd0);
        cyc();
        idle_all();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
